// File: rtl/can_rx_filter_fifo_pkg.sv
// Shared types and widths for the CAN RX filter/FIFO slice.
// Optional CAN_RX_TIMESTAMP_EN adds a per-frame 16-bit timestamp to can_frame_t.
package can_rx_filter_fifo_pkg;

    localparam int unsigned ID_WIDTH    = 32;
    localparam int unsigned DATA_WIDTH  = 64;
    localparam int unsigned NUM_FILTERS = 4;
    localparam int unsigned FIDX_W      = $clog2(NUM_FILTERS + 1);
    localparam int unsigned CAN_TS_W    = 16;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } can_flush_state_e;

    typedef struct packed {
`ifdef CAN_RX_TIMESTAMP_EN
        logic [CAN_TS_W-1:0]   ts;
`endif
        logic [FIDX_W-1:0]     fidx;
        logic [DATA_WIDTH-1:0] data;
        logic [ID_WIDTH-1:0]   id;
    } can_frame_t;

endpackage

// File: rtl/can_rx_filter_fifo_if.sv
// RX-handler capture handshake and host-side valid/ready frame output.
// out_ts exists only when CAN_RX_TIMESTAMP_EN is defined.
interface can_rx_filter_fifo_if;
    import can_rx_filter_fifo_pkg::*;

    logic [ID_WIDTH-1:0]   rx_id;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_ready;
    logic                  rx_ack;
    logic                  out_valid;
    logic                  out_ready;
    logic [ID_WIDTH-1:0]   out_id;
    logic [DATA_WIDTH-1:0] out_data;
    logic [FIDX_W-1:0]     out_fidx;
`ifdef CAN_RX_TIMESTAMP_EN
    logic [CAN_TS_W-1:0]   out_ts;
`endif

    modport slave (
        input  rx_id, rx_data, rx_ready, out_ready,
`ifdef CAN_RX_TIMESTAMP_EN
        output out_ts,
`endif
        output rx_ack, out_valid, out_id, out_data, out_fidx
    );

    modport master (
        output rx_id, rx_data, rx_ready, out_ready,
`ifdef CAN_RX_TIMESTAMP_EN
        input  out_ts,
`endif
        input  rx_ack, out_valid, out_id, out_data, out_fidx
    );

endinterface

// File: rtl/can_rx_filter_fifo_sync_fifo.sv
// Single-clock FIFO with registered head output, flush, and pop-before-push when full.
// Head output holds its last value while the FIFO is empty.
module can_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full_c,
    output logic                     empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [CW-1:0]    count_d;
    logic [WIDTH-1:0] head_d;
    logic             valid_d, push_ok, pop_ok;

    assign full_c  = (count == CW'(DEPTH));
    assign empty_c = (count == '0);

    // Next pointers/count and the value the head register must show after this edge
    always_comb begin
        pop_ok   = pop && !empty_c;
        push_ok  = push && (!full_c || pop_ok);
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count;
        if (push_ok && !pop_ok) begin
            count_d = count + CW'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count - CW'(1);
        end
        valid_d = (count_d != '0);
        head_d  = dout;
        if (count_d != '0) begin
            head_d = (push_ok && (rd_ptr_d == wr_ptr_q)) ? din : mem[rd_ptr_d];
        end
        if (flush) begin
            push_ok  = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            valid_d  = 1'b0;
            head_d   = dout;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
            valid    <= 1'b0;
            dout     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count    <= count_d;
            valid    <= valid_d;
            dout     <= head_d;
        end
    end

endmodule

// File: rtl/can_rx_filter_fifo.sv
// CAN RX capture, mask/ID acceptance filtering and frame FIFO with drop statistics.
// Optional CAN_RX_TIMESTAMP_EN: free-running 16-bit timestamp captured per frame, shown on out_ts.
module can_rx_filter_fifo
    import can_rx_filter_fifo_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                            clk_can,
    input  logic                            rst_n,
    can_rx_filter_fifo_if.slave             bus,
    input  logic [NUM_FILTERS*ID_WIDTH-1:0] flt_id,
    input  logic [NUM_FILTERS*ID_WIDTH-1:0] flt_mask,
    input  logic [NUM_FILTERS-1:0]          flt_en,
    input  logic                            accept_all,
    input  logic                            flush,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow,
    input  logic                            overflow_clr,
    output logic [15:0]                     drop_cnt
);

    can_flush_state_e state_q, state_d;
    logic             flushing;

    logic                  s1_vld;
    logic [ID_WIDTH-1:0]   s1_id;
    logic [DATA_WIDTH-1:0] s1_data;
`ifdef CAN_RX_TIMESTAMP_EN
    logic [CAN_TS_W-1:0]   ts_cnt;
    logic [CAN_TS_W-1:0]   s1_ts;
`endif

    logic [NUM_FILTERS-1:0] match;
    logic                   match_any, accept, fifo_push, fifo_pop;
    logic                   reject_drop, ovf_drop;
    logic [FIDX_W-1:0]      fidx;
    can_frame_t             s2_frame, head;
    logic                   fifo_valid, fifo_full, fifo_empty;

    // Flush sequencer: one FLUSH cycle per request, always returns to RUN
    always_ff @(posedge clk_can or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        flushing = 1'b0;
        case (state_q)
            RUN:     if (flush) state_d = FLUSH;
            FLUSH: begin
                flushing = 1'b1;
                state_d  = RUN;
            end
            default: state_d = RUN;
        endcase
    end

`ifdef CAN_RX_TIMESTAMP_EN
    always_ff @(posedge clk_can or negedge rst_n) begin
        if (!rst_n) ts_cnt <= '0;
        else        ts_cnt <= ts_cnt + CAN_TS_W'(1);
    end
`endif

    // S1 capture; s1_vld doubles as the one-cycle ack to the RX handler
    always_ff @(posedge clk_can or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_id   <= '0;
            s1_data <= '0;
`ifdef CAN_RX_TIMESTAMP_EN
            s1_ts   <= '0;
`endif
        end else begin
            s1_vld <= bus.rx_ready;
            if (bus.rx_ready) begin
                s1_id   <= bus.rx_id;
                s1_data <= bus.rx_data;
`ifdef CAN_RX_TIMESTAMP_EN
                s1_ts   <= ts_cnt;
`endif
            end
        end
    end

    assign bus.rx_ack = s1_vld;

    for (genvar g = 0; g < NUM_FILTERS; g++) begin : g_match
        assign match[g] = flt_en[g] &&
            (((s1_id ^ flt_id[g*ID_WIDTH +: ID_WIDTH]) & flt_mask[g*ID_WIDTH +: ID_WIDTH]) == '0);
    end

    // S2: lowest matching filter wins; walk downward so the last hit is the lowest index
    always_comb begin
        match_any = 1'b0;
        fidx      = FIDX_W'(NUM_FILTERS);
        for (int i = NUM_FILTERS - 1; i >= 0; i--) begin
            if (match[i]) begin
                match_any = 1'b1;
                fidx      = FIDX_W'(i);
            end
        end
        accept      = accept_all || match_any;
        fifo_pop    = bus.out_ready && !fifo_empty;
        fifo_push   = s1_vld && accept && !flushing;
        reject_drop = s1_vld && !accept && !flushing;
        ovf_drop    = fifo_push && fifo_full && !fifo_pop;

        s2_frame      = '0;
        s2_frame.id   = s1_id;
        s2_frame.data = s1_data;
        s2_frame.fidx = fidx;
`ifdef CAN_RX_TIMESTAMP_EN
        s2_frame.ts   = s1_ts;
`endif
    end

    // Drop statistics; a fresh overflow beats a simultaneous clear
    always_ff @(posedge clk_can or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (ovf_drop)          overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
            if ((reject_drop || ovf_drop) && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    can_sync_fifo #(
        .WIDTH ($bits(can_frame_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_can),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .din     (s2_frame),
        .pop     (fifo_pop),
        .flush   (flushing),
        .dout    (head),
        .valid   (fifo_valid),
        .count   (fifo_count),
        .full_c  (fifo_full),
        .empty_c (fifo_empty)
    );

    assign bus.out_valid = fifo_valid;
    assign bus.out_id    = head.id;
    assign bus.out_data  = head.data;
    assign bus.out_fidx  = head.fidx;
`ifdef CAN_RX_TIMESTAMP_EN
    assign bus.out_ts    = head.ts;
`endif

endmodule

// File: tb/tb_can_rx_filter_fifo.sv
// Directed bench for can_rx_filter_fifo: filtering, overflow, pop-before-push, back-to-back, flush.
// Timestamp spacing is checked when CAN_RX_TIMESTAMP_EN is defined.
module tb_can_rx_filter_fifo;
    import can_rx_filter_fifo_pkg::*;

    logic                            clk_can = 1'b0;
    logic                            rst_n   = 1'b0;
    logic [NUM_FILTERS*ID_WIDTH-1:0] flt_id;
    logic [NUM_FILTERS*ID_WIDTH-1:0] flt_mask;
    logic [NUM_FILTERS-1:0]          flt_en;
    logic                            accept_all;
    logic                            flush;
    logic [4:0]                      fifo_count;
    logic                            overflow;
    logic                            overflow_clr;
    logic [15:0]                     drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    can_rx_filter_fifo_if bus ();

    can_rx_filter_fifo #(.FIFO_DEPTH(16)) dut (
        .clk_can      (clk_can),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .flt_id       (flt_id),
        .flt_mask     (flt_mask),
        .flt_en       (flt_en),
        .accept_all   (accept_all),
        .flush        (flush),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk_can = ~clk_can;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_can);
        #1;
    endtask

    // One rx_ready pulse, then the ack cycle is checked
    task automatic send(input logic [31:0] id, input logic [63:0] data);
        bus.rx_id    = id;
        bus.rx_data  = data;
        bus.rx_ready = 1'b1;
        step();
        bus.rx_ready = 1'b0;
        check("rx_ack", 64'(bus.rx_ack), 64'd1);
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

`ifdef CAN_RX_TIMESTAMP_EN
    logic [15:0] ts_a;
`endif

    initial begin
        bus.rx_id     = '0;
        bus.rx_data   = '0;
        bus.rx_ready  = 1'b0;
        bus.out_ready = 1'b0;
        flt_id        = '0;
        flt_mask      = '0;
        flt_en        = '0;
        accept_all    = 1'b0;
        flush         = 1'b0;
        overflow_clr  = 1'b0;
        repeat (2) step();

        check("rst_rx_ack",    64'(bus.rx_ack),    64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_id",    64'(bus.out_id),    64'd0);
        check("rst_out_data",  bus.out_data,       64'd0);
        check("rst_out_fidx",  64'(bus.out_fidx),  64'd0);
        check("rst_count",     64'(fifo_count),    64'd0);
        check("rst_overflow",  64'(overflow),      64'd0);
        check("rst_drop_cnt",  64'(drop_cnt),      64'd0);
        rst_n = 1'b1;
        step();

        // Exact-match filter 0, accepted frame reaches the head two cycles after rx_ready
        flt_id[0*32 +: 32]   = 32'h123;
        flt_mask[0*32 +: 32] = 32'h7FF;
        flt_en               = 4'b0001;
        send(32'h123, 64'hDEAD_BEEF_0000_0001);
        check("acc_valid_early", 64'(bus.out_valid), 64'd0);
        step();
        check("acc_ack_once",  64'(bus.rx_ack),    64'd0);
        check("acc_valid",     64'(bus.out_valid), 64'd1);
        check("acc_id",        64'(bus.out_id),    64'h123);
        check("acc_data",      bus.out_data,       64'hDEAD_BEEF_0000_0001);
        check("acc_fidx",      64'(bus.out_fidx),  64'd0);
        pop_one();
        check("pop_empty_valid", 64'(bus.out_valid), 64'd0);
        check("pop_empty_hold",  64'(bus.out_id),    64'h123);

        // Rejected frame: acked, not stored, counted as a drop
        send(32'h124, 64'h1);
        step();
        check("rej_count",    64'(fifo_count), 64'd0);
        check("rej_drop",     64'(drop_cnt),   64'd1);
        check("rej_overflow", 64'(overflow),   64'd0);

        // Priority: filter 1 exact, filter 2 wildcard; masked-off upper ID bits are ignored
        flt_id[1*32 +: 32]   = 32'h124;
        flt_mask[1*32 +: 32] = 32'h7FF;
        flt_id[2*32 +: 32]   = 32'h0;
        flt_mask[2*32 +: 32] = 32'h0;
        flt_en               = 4'b0111;
        send(32'h124, 64'h2);
        step();
        check("pri_fidx1", 64'(bus.out_fidx), 64'd1);
        pop_one();
        send(32'h555, 64'h3);
        step();
        check("pri_fidx2", 64'(bus.out_fidx), 64'd2);
        pop_one();
        send(32'h8000_0123, 64'h4);
        step();
        check("mask_fidx0", 64'(bus.out_fidx), 64'd0);
        check("mask_id",    64'(bus.out_id),   64'h8000_0123);
        pop_one();
        check("prio_drop", 64'(drop_cnt), 64'd1);

        // accept_all with filters off: 17 frames into a 16-deep FIFO
        flt_en     = '0;
        accept_all = 1'b1;
        for (int k = 0; k < 17; k++) begin
            bus.rx_id    = 32'h100 + 32'(k);
            bus.rx_data  = 64'(k);
            bus.rx_ready = 1'b1;
            step();
        end
        bus.rx_ready = 1'b0;
        step();
        check("ovf_count", 64'(fifo_count),   64'd16);
        check("ovf_flag",  64'(overflow),     64'd1);
        check("ovf_drop",  64'(drop_cnt),     64'd2);
        check("ovf_head",  64'(bus.out_id),   64'h100);
        check("ovf_fidx",  64'(bus.out_fidx), 64'd4);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        check("ovf_clr", 64'(overflow), 64'd0);

        // Full FIFO: pop in the same cycle as the S2 push makes room
        send(32'h200, 64'h200);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("pbp_count",    64'(fifo_count), 64'd16);
        check("pbp_drop",     64'(drop_cnt),   64'd2);
        check("pbp_overflow", 64'(overflow),   64'd0);
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            check("pbp_valid", 64'(bus.out_valid), 64'd1);
            check("pbp_order", 64'(bus.out_id), (k == 16) ? 64'h200 : 64'(32'h100 + 32'(k)));
            step();
        end
        check("drain_valid", 64'(bus.out_valid), 64'd0);
        step();
        check("empty_pop_ignored", 64'(fifo_count), 64'd0);
        bus.out_ready = 1'b0;

        // Back-to-back rx_ready on four consecutive cycles
        for (int k = 1; k <= 4; k++) begin
            bus.rx_id    = 32'(k);
            bus.rx_ready = 1'b1;
            step();
            check("b2b_ack", 64'(bus.rx_ack), 64'd1);
        end
        bus.rx_ready = 1'b0;
        step();
        check("b2b_ack_end", 64'(bus.rx_ack),  64'd0);
        check("b2b_count",   64'(fifo_count),  64'd4);
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("b2b_order", 64'(bus.out_id), 64'(k));
            step();
        end
        bus.out_ready = 1'b0;
        check("b2b_empty", 64'(bus.out_valid), 64'd0);

        // Flush with five queued frames and a sixth in flight
        for (int k = 0; k < 5; k++) begin
            bus.rx_id    = 32'h31 + 32'(k);
            bus.rx_ready = 1'b1;
            step();
        end
        bus.rx_ready = 1'b0;
        step();
        check("fl_pre_count", 64'(fifo_count), 64'd5);
        bus.rx_id    = 32'h36;
        bus.rx_ready = 1'b1;
        flush        = 1'b1;
        step();
        bus.rx_ready = 1'b0;
        flush        = 1'b0;
        check("fl_ack", 64'(bus.rx_ack), 64'd1);
        step();
        check("fl_count", 64'(fifo_count),    64'd0);
        check("fl_valid", 64'(bus.out_valid), 64'd0);
        check("fl_drop",  64'(drop_cnt),      64'd2);
        step();
        check("fl_discard", 64'(fifo_count), 64'd0);
        send(32'h77, 64'h77);
        step();
        check("fl_resume", 64'(bus.out_id), 64'h77);
        pop_one();

`ifdef CAN_RX_TIMESTAMP_EN
        // Frames captured 100 cycles apart
        send(32'hA, 64'hA);
        step();
        ts_a = bus.out_ts;
        pop_one();
        repeat (97) step();
        send(32'hB, 64'hB);
        step();
        check("ts_delta", 64'(bus.out_ts - ts_a), 64'd100);
        pop_one();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
